// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store requesters.
// Define MEM_PORT_ARBITER_RR_EN for round-robin contention; default is data priority with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR       = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [ADDR-1:0]  if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_wr_en,
  input  logic [ADDR-1:0]  d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_wr_en,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_D} resp_t;

  resp_t resp_owner;
  resp_t resp_next;
  logic  both_req;
  logic  if_wins;

  assign both_req = if_req && d_req;

`ifdef MEM_PORT_ARBITER_RR_EN
  typedef enum logic {LAST_IF, LAST_D} last_t;

  last_t last_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= LAST_IF;
    end else if (if_gnt) begin
      last_gnt <= LAST_IF;
    end else if (d_gnt) begin
      last_gnt <= LAST_D;
    end
  end

  assign if_wins = (last_gnt == LAST_D);
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  // Counts only cycles where fetch is waiting; any grant or idle fetch clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt < STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign if_wins = (starve_cnt == STARVE_LIM);
`endif

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (both_req) begin
        if_gnt = if_wins;
        d_gnt  = !if_wins;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  assign busy = both_req && !reset;

  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    resp_next = RESP_NONE;
    if (if_gnt) begin
      mem_addr  = if_addr;
      resp_next = RESP_IF;
    end else if (d_gnt) begin
      mem_wr_en = d_wr_en;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      resp_next = d_wr_en ? RESP_NONE : RESP_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_owner <= RESP_NONE;
    end else begin
      resp_owner <= resp_next;
    end
  end

  assign if_rvalid = (resp_owner == RESP_IF);
  assign d_rvalid  = (resp_owner == RESP_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboarded read responses, reset and contention sequences.
// Build with MEM_PORT_ARBITER_RR_EN defined to check the round-robin variant.
module tb_mem_port_arbiter;

  localparam int WIDTH = 32;
  localparam int ADDR  = 5;
  localparam int DEPTH = 1 << ADDR;

  logic             clk = 1'b0;
  logic             reset;
  logic             if_req;
  logic [ADDR-1:0]  if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;
  logic             d_req;
  logic             d_wr_en;
  logic [ADDR-1:0]  d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;
  logic             mem_wr_en;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             busy;

  mem_port_arbiter #(
    .WIDTH(WIDTH),
    .ADDR(ADDR),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req),
    .d_wr_en(d_wr_en),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_gnt(d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] init_word(input int unsigned i);
    if (i == 3) return 32'hDEADBEEF;
    return 32'h1000_0000 + i * 32'h0101_0101;
  endfunction

  // Synchronous-read single-port memory macro.
  logic             mem_load;
  logic [WIDTH-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  logic [WIDTH-1:0] ref_mem [DEPTH];

  typedef struct {
    logic [1:0]       owner;  // 0 none, 1 fetch, 2 data
    logic [WIDTH-1:0] data;
  } resp_exp_t;

  resp_exp_t sb[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_resp(input string tag);
    resp_exp_t e;
    if (sb.size() == 0) begin
      e.owner = 2'd0;
      e.data  = '0;
    end else begin
      e = sb.pop_front();
    end
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(e.owner == 2'd1));
    chk({tag, ".if_rdata"},  if_rdata, (e.owner == 2'd1) ? e.data : '0);
    chk({tag, ".d_rvalid"},  32'(d_rvalid), 32'(e.owner == 2'd2));
    chk({tag, ".d_rdata"},   d_rdata, (e.owner == 2'd2) ? e.data : '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".if_gnt"},    32'(if_gnt), 32'd0);
    chk({tag, ".d_gnt"},     32'(d_gnt), 32'd0);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, ".d_rvalid"},  32'(d_rvalid), 32'd0);
    chk({tag, ".if_rdata"},  if_rdata, '0);
    chk({tag, ".d_rdata"},   d_rdata, '0);
    chk({tag, ".mem_wr_en"}, 32'(mem_wr_en), 32'd0);
    chk({tag, ".mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, '0);
    chk({tag, ".busy"},      32'(busy), 32'd0);
  endtask

  // One clock cycle: check the response owed from last cycle, drive new requests, check grant and memory port.
  task automatic cycle(input string tag, input logic ir, input logic [ADDR-1:0] ia,
                       input logic dr, input logic dw, input logic [ADDR-1:0] da,
                       input logic [WIDTH-1:0] dd, input logic eig, input logic edg);
    resp_exp_t e;
    @(posedge clk);
    #1;
    check_resp(tag);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_wr_en = dw;
    d_addr  = da;
    d_wdata = dd;
    #1;
    chk({tag, ".if_gnt"},    32'(if_gnt), 32'(eig));
    chk({tag, ".d_gnt"},     32'(d_gnt), 32'(edg));
    chk({tag, ".busy"},      32'(busy), 32'(ir && dr));
    chk({tag, ".mem_wr_en"}, 32'(mem_wr_en), 32'(edg && dw));
    chk({tag, ".mem_addr"},  32'(mem_addr), eig ? 32'(ia) : (edg ? 32'(da) : 32'd0));
    chk({tag, ".mem_wdata"}, mem_wdata, edg ? dd : '0);
    e.owner = eig ? 2'd1 : ((edg && !dw) ? 2'd2 : 2'd0);
    e.data  = eig ? ref_mem[ia] : ref_mem[da];
    sb.push_back(e);
    if (edg && dw) ref_mem[da] = dd;
  endtask

  typedef struct {
    logic             ir;
    logic [ADDR-1:0]  ia;
    logic             dr;
    logic             dw;
    logic [ADDR-1:0]  da;
    logic [WIDTH-1:0] dd;
    logic             eig;
    logic             edg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic eig;

    vecs[0]  = '{1'b1, 5'd3,  1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  1'b1, 1'b1, 5'd7,  32'h1234_5678, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 5'd0,  1'b1, 1'b0, 5'd7,  32'h0,         1'b0, 1'b1};
    vecs[3]  = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd7,  1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd5,  1'b1, 1'b0, 5'd9,  32'h0,         1'b0, 1'b1};
    vecs[6]  = '{1'b1, 5'd5,  1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  1'b1, 1'b1, 5'd31, 32'hCAFE_F00D, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 5'd31, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  1'b0, 1'b1, 5'd12, 32'h55AA_55AA, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  1'b1, 1'b0, 5'd12, 32'h0,         1'b0, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};

    for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Power-on reset with both requests asserted: grants must stay low.
    reset    = 1'b1;
    mem_load = 1'b1;
    if_req   = 1'b1;
    if_addr  = 5'd3;
    d_req    = 1'b1;
    d_wr_en  = 1'b1;
    d_addr   = 5'd7;
    d_wdata  = 32'hFFFF_FFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    if_req   = 1'b0;
    d_req    = 1'b0;
    d_wr_en  = 1'b0;
    reset    = 1'b0;
    mem_load = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
            vecs[i].da, vecs[i].dd, vecs[i].eig, vecs[i].edg);
    end

    // Reset arriving while a fetch response is pending drops it for good.
    cycle("mid_rst_gnt", 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rst.pending_rvalid", 32'(if_rvalid), 32'd1);
    d_req = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b0;

    // Sustained contention straight out of reset.
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_PORT_ARBITER_RR_EN
      eig = (k % 2) == 1;
`else
      eig = (k % 5) == 4;
`endif
      cycle($sformatf("cont%0d", k), 1'b1, 5'd2, 1'b1, 1'b0, 5'd4, 32'h0, eig, !eig);
    end

    for (int k = 0; k < 10; k++) begin
      cycle($sformatf("idle%0d", k), 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-port memory instance between the instruction-fetch requester and the load/store requester of the RISC-V core. It sits between the datapath's fetch/data address outputs and a single `memory` macro, granting one access per cycle and returning read data one cycle after the grant. It enables a unified instruction/data memory without changing the datapath's addressing.

## Interface
Parameters:
- WIDTH, 32, data word width
- ADDR, 5, word-address width
- STARVE_MAX, 4, fixed-priority mode only: consecutive cycles fetch may be denied before it is forced (range 1..15)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- if_req  input  1  fetch read request; held until if_gnt
- if_addr  input  ADDR  fetch word address
- if_gnt  output  1  fetch accepted this cycle
- if_rvalid  output  1  fetch read data valid
- if_rdata  output  WIDTH  fetch read data
- d_req  input  1  data request; held until d_gnt
- d_wr_en  input  1  1 = write, 0 = read
- d_addr  input  ADDR  data word address
- d_wdata  input  WIDTH  write data
- d_gnt  output  1  data access accepted this cycle
- d_rvalid  output  1  data read data valid (reads only)
- d_rdata  output  WIDTH  data read data
- mem_wr_en  output  1  memory write enable
- mem_addr  output  ADDR  memory address
- mem_wdata  output  WIDTH  memory write data
- mem_rdata  input  WIDTH  memory read data, valid one cycle after address
- busy  output  1  high when both requesters are requesting in the same cycle (contention indicator)

## Operation
- At most one of if_gnt/d_gnt is high per cycle; grants are combinational from requests and arbiter state.
- Single requester: granted immediately.
- Both requesting, fixed-priority mode: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt (4 bits): +1 each cycle with if_req && !if_gnt, saturating at STARVE_MAX; cleared on if_gnt or !if_req.
- Granted side drives mem_addr/mem_wr_en/mem_wdata that cycle; fetch always reads (mem_wr_en=0, mem_wdata=0).
- No grant: mem_wr_en=0, mem_addr=0, mem_wdata=0.
- Response register resp_owner {NONE, IF, D} captures the read grant; next cycle the matching rvalid is high and its rdata = mem_rdata. Non-owner rdata is 0. Writes set resp_owner = NONE.
- Back-to-back grants permitted every cycle; a response and a new grant may coexist.

## Timing
- Grant in cycle N -> memory access in cycle N -> rvalid and rdata in cycle N+1. Read latency: 1 cycle.
- Write is complete at the clock edge ending cycle N. A read of the same address granted at N+1 returns the new data.
- Reset values: if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0, starve_cnt=0, resp_owner=NONE, last_gnt=IF.
- While reset is high, all grants are forced to 0.
- Reset asserted mid-operation: a pending rvalid is dropped immediately and is never reissued. The requester must re-request.
- Dropping a request before its grant is illegal. Behaviour in that case is unspecified.

## Configuration
- MEM_PORT_ARBITER_RR_EN defined: round-robin on contention. The winner is the requester not in last_gnt.
  - last_gnt updates on every grant.
  - starve_cnt and STARVE_MAX are unused; starve_cnt is held at 0.
- MEM_PORT_ARBITER_RR_EN undefined: fixed data priority with the starvation guard described above. last_gnt is unused.

## Test plan
- Fetch only: if_req=1, if_addr=3, mem holds 0xDEADBEEF at 3 -> if_gnt in the same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Data write then read: d_wr_en=1, d_addr=7, d_wdata=0x12345678, followed by a read of 7 -> no d_rvalid for the write; the read returns 0x12345678 one cycle after its grant.
- Contention, fixed mode, STARVE_MAX=4, both requests held continuously -> d_gnt for 4 cycles, then if_gnt in the 5th cycle, starve_cnt cleared. busy=1 throughout.
- Contention with MEM_PORT_ARBITER_RR_EN defined, both requests held after reset -> grants D, IF, D, IF alternate each cycle. rvalid alternates one cycle later.
- Reset mid-read: assert reset the cycle after if_gnt -> if_rvalid=0 immediately, and all outputs take their reset values.
- Idle: no requests for 10 cycles -> mem_wr_en=0, mem_addr=0, and no rvalid asserted.
